mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 32-bit memory port between two masters with a round-robin scheduler that switches only at transaction boundaries.
- m0 is the CPU and m1 is the loader/debug DMA.
- Sits between the masters and the block-RAM controller.
- Masters hold each request until it is acknowledged. Both masters gain m*_wr_ack as a write handshake; the CPU write states wait on it.

Parameters:
AW, 16, address width
DW, 32, data width (byte mask width DW/8)
BURST, 4, max consecutive completed transactions by one owner while the other master waits (1..15)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  reset, asynchronous, active-low
m0_rd_en / m1_rd_en  in  1  read request, held until m*_rd_valid
m0_wr_en / m1_wr_en  in  1  write request, held until m*_wr_ack
m0_addr / m1_addr  in  AW  byte address, stable while requesting
m0_wr_data / m1_wr_data  in  DW  write data
m0_wr_mask / m1_wr_mask  in  DW/8  byte enables
m0_rd_data / m1_rd_data  out  DW  read data (s_rd_data broadcast)
m0_rd_valid / m1_rd_valid  out  1  read complete, 1 cycle
m0_wr_ack / m1_wr_ack  out  1  write accepted, 1 cycle
s_rd_en  out  1  read strobe to memory
s_wr_en  out  1  write strobe to memory
s_addr  out  AW  address (all-ones when no forward)
s_wr_data  out  DW  write data (0 when no forward)
s_wr_mask  out  DW/8  byte enables (4'b1111 when no forward)
s_rd_data  in  DW  memory read data
s_rd_valid  in  1  read data valid, >=1 cycle after s_rd_en with address held

Behaviour:
- Registers: owner (0/1), in_flight (1b), burst_cnt (4b). Reset values: owner=0, in_flight=0, burst_cnt=0.
- The master with req = rd_en|wr_en drives the s_* outputs combinationally when it is the owner. Otherwise s_* carry the idle values listed under Ports.
- At reset and with no requests, all s_* and m_* outputs are idle/0.
- Write: forwarded in the cycle owner's wr_en=1. m_wr_ack=1 in that same cycle, giving 0 extra latency.
- If rd_en and wr_en are both set, only the write is forwarded and acked. The read waits for a later cycle.
- Read: s_rd_en is forwarded each cycle until s_rd_valid. in_flight is set on the first forwarded cycle.
- m_rd_valid(owner) = s_rd_valid & in_flight. in_flight clears on s_rd_valid.
- A non-owner's rd_valid/wr_ack is always 0.
- Completion event is a write ack or a read valid.
- On completion:
  - If the other master is requesting, owner flips next cycle and burst_cnt is cleared. The other master is never made to wait more than one transaction, and burst_cnt never reaches BURST.
  - Otherwise owner stays (parking) and burst_cnt saturates at BURST.
- If owner is idle (no req, in_flight=0) and the other requests: owner flips next cycle with burst_cnt=0. This costs a 1-cycle switch bubble during which s_* are idle.
- If owner is requesting and the other is requesting: the switch happens only at the owner's completion. A read in flight is never preempted.
- Owner drops rd_en before s_rd_valid (protocol violation):
  - in_flight stays set and ownership is held until s_rd_valid.
  - That data is discarded (m_rd_valid=0 since rd_en=0), then normal arbitration resumes.
- Simultaneous first requests after reset: m0 wins (owner reset value).
- rst_n low mid-read: in_flight clears immediately. A late s_rd_valid after release is ignored unless a new read is in flight.
- Throughput: a same-owner back-to-back read completes every s_rd_valid. A 1-cycle-latency memory gives 2 cycles/read including re-request.

Test Plan:
1. Reset, m0 read addr 0x0080, memory returns 0xDEADBEEF after 1 cycle -> s_rd_en=1 with s_addr=0x0080. m0_rd_valid=1 and m0_rd_data=0xDEADBEEF next cycle. m1_rd_valid=0.
2. m0 and m1 request reads simultaneously from reset -> m0 served first. At m0's valid, owner flips. m1 is served next with no bubble. m0's re-request waits exactly one m1 transaction.
3. m1 holds continuous writes (addr 0x0100.., mask 4'b0011) while m0 idle -> wr_ack every cycle and burst_cnt saturates at 4. m0 read arrives -> granted after m1's current ack. Writes alternate afterwards.
4. Owner m0 parked idle, m1 write 0x12345678 to 0x0008 -> 1 bubble cycle with s_wr_en=0, then s_wr_en=1 and m1_wr_ack=1.
5. m0 sets rd_en and wr_en together at 0x0010 -> only s_wr_en asserted and wr_ack given. The read follows in the next owned cycle.
6. rst_n pulled low while m1 read in flight, s_rd_valid arrives during reset -> no m*_rd_valid. After release, owner=0 and all s_* outputs idle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single block-RAM port. Ownership only
// changes at transaction boundaries; m0 (CPU) wins the first tie after reset.
module mem_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_rd_en,
  input  logic            m0_wr_en,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wr_data,
  input  logic [DW/8-1:0] m0_wr_mask,
  output logic [DW-1:0]   m0_rd_data,
  output logic            m0_rd_valid,
  output logic            m0_wr_ack,
  input  logic            m1_rd_en,
  input  logic            m1_wr_en,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wr_data,
  input  logic [DW/8-1:0] m1_wr_mask,
  output logic [DW-1:0]   m1_rd_data,
  output logic            m1_rd_valid,
  output logic            m1_wr_ack,
  output logic            s_rd_en,
  output logic            s_wr_en,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wr_data,
  output logic [DW/8-1:0] s_wr_mask,
  input  logic [DW-1:0]   s_rd_data,
  input  logic            s_rd_valid
);

  logic            owner, in_flight;
  logic [3:0]      burst_cnt;
  logic            own_rd, own_wr, own_req, oth_req;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_data;
  logic [DW/8-1:0] own_mask;
  logic            wr_fwd, rd_fwd, rd_done, done;

  always_comb begin
    own_rd   = owner ? m1_rd_en   : m0_rd_en;
    own_wr   = owner ? m1_wr_en   : m0_wr_en;
    own_addr = owner ? m1_addr    : m0_addr;
    own_data = owner ? m1_wr_data : m0_wr_data;
    own_mask = owner ? m1_wr_mask : m0_wr_mask;
    own_req  = own_rd | own_wr;
    oth_req  = owner ? (m0_rd_en | m0_wr_en) : (m1_rd_en | m1_wr_en);
    // A write never interrupts a read already waiting on memory data.
    wr_fwd   = own_wr & ~in_flight;
    rd_fwd   = own_rd & ~wr_fwd;
    rd_done  = s_rd_valid & in_flight;
    done     = wr_fwd | rd_done;
  end

  always_comb begin
    s_rd_en   = rd_fwd;
    s_wr_en   = wr_fwd;
    s_addr    = '1;
    s_wr_data = '0;
    s_wr_mask = '1;
    if (rd_fwd | wr_fwd) begin
      s_addr    = own_addr;
      s_wr_data = own_data;
      s_wr_mask = own_mask;
    end
  end

  // Read data is only delivered if the owner still holds rd_en; otherwise discarded.
  assign m0_rd_data  = s_rd_data;
  assign m1_rd_data  = s_rd_data;
  assign m0_rd_valid = ~owner & rd_done & m0_rd_en;
  assign m1_rd_valid =  owner & rd_done & m1_rd_en;
  assign m0_wr_ack   = ~owner & wr_fwd;
  assign m1_wr_ack   =  owner & wr_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      in_flight <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (rd_done)     in_flight <= 1'b0;
      else if (rd_fwd) in_flight <= 1'b1;

      if (done) begin
        if (oth_req) begin
          owner     <= ~owner;
          burst_cnt <= '0;
        end else if (burst_cnt < 4'(BURST)) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else if (!own_req && !in_flight && oth_req) begin
        // Idle owner hands over; costs one bubble cycle.
        owner     <= ~owner;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two master drivers, a 1-cycle-latency
// memory model, and expected completions queued per master at issue time.
module tb_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  mk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en [2];
  logic        wr_en [2];
  logic [15:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wmask [2];
  logic [31:0] rd_data [2];
  logic        rd_valid [2];
  logic        wr_ack [2];
  logic        s_rd_en, s_wr_en;
  logic [15:0] s_addr;
  logic [31:0] s_wr_data, s_rd_data;
  logic [3:0]  s_wr_mask;
  logic        s_rd_valid;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        mvalid = 1'b0;
  logic [31:0] mdata = '0;
  logic        mem_off = 1'b0;
  logic        inj = 1'b0;

  exp_t q0 [$];
  exp_t q1 [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  mem_arbiter #(.AW(16), .DW(32), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en(rd_en[0]), .m0_wr_en(wr_en[0]), .m0_addr(addr[0]),
    .m0_wr_data(wdata[0]), .m0_wr_mask(wmask[0]), .m0_rd_data(rd_data[0]),
    .m0_rd_valid(rd_valid[0]), .m0_wr_ack(wr_ack[0]),
    .m1_rd_en(rd_en[1]), .m1_wr_en(wr_en[1]), .m1_addr(addr[1]),
    .m1_wr_data(wdata[1]), .m1_wr_mask(wmask[1]), .m1_rd_data(rd_data[1]),
    .m1_rd_valid(rd_valid[1]), .m1_wr_ack(wr_ack[1]),
    .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask),
    .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data returns the cycle after s_rd_en is sampled, address held.
  assign s_rd_data  = mdata;
  assign s_rd_valid = mvalid | inj;
  always @(posedge clk) begin
    if (s_wr_en)
      for (int b = 0; b < 4; b++)
        if (s_wr_mask[b]) mem[s_addr[9:2]][8*b +: 8] <= s_wr_data[8*b +: 8];
    mvalid <= mem_off ? 1'b0 : (s_rd_en & ~mvalid);
    mdata  <= mem[s_addr[9:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input exp_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Completion monitor: pops the owning master's queue on every rd_valid/wr_ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        if (rd_valid[m] || wr_ack[m]) begin
          e = '0;
          if ((m == 0 ? q0.size() : q1.size()) == 0) check("sb_empty", 64'd1, 64'd0);
          else e = (m == 0) ? q0.pop_front() : q1.pop_front();
          if (wr_ack[m])
            check($sformatf("wr_fwd_m%0d", m), {15'd0, 1'b1, s_addr, s_wr_data, s_wr_mask},
                  {15'd0, e.wr, e.a, e.d, e.mk});
          else
            check($sformatf("rd_data_m%0d", m), {31'd0, 1'b0, rd_data[m]}, {31'd0, e.wr, e.d});
        end
      end
    end
  end

  task automatic wait_done(input int m, input bit wr, output int c);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (wr ? wr_ack[m] : rd_valid[m]) break;
      n++;
      if (n > 60) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
    end
    c = cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_rd(input int m, input logic [15:0] a, output int c);
    push(m, '{wr: 1'b0, a: a, d: ref_mem[a[9:2]], mk: 4'h0});
    rd_en[m] = 1'b1;
    addr[m]  = a;
    wait_done(m, 1'b0, c);
    rd_en[m] = 1'b0;
  endtask

  task automatic do_wr(input int m, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] mk, output int c);
    for (int b = 0; b < 4; b++)
      if (mk[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    push(m, '{wr: 1'b1, a: a, d: d, mk: mk});
    wr_en[m] = 1'b1;
    addr[m]  = a;
    wdata[m] = d;
    wmask[m] = mk;
    wait_done(m, 1'b1, c);
    wr_en[m] = 1'b0;
  endtask

  function automatic logic [53:0] idle_vec();
    return {s_rd_en, s_wr_en, s_addr, s_wr_data, s_wr_mask};
  endfunction

  localparam logic [53:0] IDLE = {1'b0, 1'b0, 16'hFFFF, 32'h0, 4'hF};

  int t0a, t0b, t1, c, r0;
  int wc [10];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {16'hA5A5, 8'h00, 8'(i)};
      ref_mem[i] = {16'hA5A5, 8'h00, 8'(i)};
    end
    mem[8'h20]     = 32'hDEADBEEF;
    ref_mem[8'h20] = 32'hDEADBEEF;
    for (int m = 0; m < 2; m++) begin
      rd_en[m] = 1'b0; wr_en[m] = 1'b0; addr[m] = '0; wdata[m] = '0; wmask[m] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_s_idle", 64'(idle_vec()), 64'(IDLE));
    check("rst_m_out", {60'd0, rd_valid[0], rd_valid[1], wr_ack[0], wr_ack[1]}, 64'd0);
    check("rst_owner", 64'(dut.owner), 64'd0);
    @(posedge clk); #1;

    // 1: single m0 read, 1-cycle memory
    push(0, '{wr: 1'b0, a: 16'h0080, d: 32'hDEADBEEF, mk: 4'h0});
    rd_en[0] = 1'b1; addr[0] = 16'h0080;
    @(negedge clk);
    check("t1_fwd", {47'd0, s_rd_en, s_addr}, {47'd0, 1'b1, 16'h0080});
    @(negedge clk);
    check("t1_valid", {62'd0, rd_valid[0], rd_valid[1]}, {62'd0, 1'b1, 1'b0});
    @(posedge clk); #1 rd_en[0] = 1'b0;

    // 2: simultaneous reads; m0 first, m1 with no bubble, m0 waits one txn
    fork
      begin do_rd(0, 16'h0040, t0a); do_rd(0, 16'h0048, t0b); end
      do_rd(1, 16'h0044, t1);
    join
    check("t2_m1_nobubble", 64'(t1 - t0a), 64'd2);
    check("t2_m0_wait1", 64'(t0b - t0a), 64'd4);

    // 3: m1 streams masked writes while m0 idle, then m0 read cuts in
    for (int i = 0; i < 6; i++)
      do_wr(1, 16'h0100 + 16'(4*i), $urandom, 4'b0011, wc[i]);
    check("t3_stream", 64'(wc[5] - wc[1]), 64'd4);
    check("t3_burst_sat", 64'(dut.burst_cnt), 64'd4);
    fork
      for (int i = 6; i < 10; i++)
        do_wr(1, 16'h0100 + 16'(4*i), $urandom, 4'b0011, wc[i]);
      do_rd(0, 16'h0060, r0);
    join
    check("t3_m0_grant", 64'(r0 - wc[6]), 64'd2);
    check("t3_m1_resume", 64'(wc[7] - wc[6]), 64'd3);
    do_rd(0, 16'h0104, c);

    // 4: m0 parked idle, m1 write pays one bubble
    do_wr(0, 16'h000C, 32'h0BADF00D, 4'hF, c);
    check("t4_owner0", 64'(dut.owner), 64'd0);
    ref_mem[2] = 32'h12345678;
    push(1, '{wr: 1'b1, a: 16'h0008, d: 32'h12345678, mk: 4'hF});
    wr_en[1] = 1'b1; addr[1] = 16'h0008; wdata[1] = 32'h12345678; wmask[1] = 4'hF;
    @(negedge clk);
    check("t4_bubble", {62'd0, s_wr_en, wr_ack[1]}, 64'd0);
    @(negedge clk);
    check("t4_write", {46'd0, s_wr_en, wr_ack[1], s_addr}, {46'd0, 1'b1, 1'b1, 16'h0008});
    @(posedge clk); #1 wr_en[1] = 1'b0;
    do_rd(0, 16'h0008, c);

    // 5: rd_en+wr_en together -> write first, read next owned cycle
    ref_mem[4] = 32'hCAFEF00D;
    push(0, '{wr: 1'b1, a: 16'h0010, d: 32'hCAFEF00D, mk: 4'hF});
    push(0, '{wr: 1'b0, a: 16'h0010, d: 32'hCAFEF00D, mk: 4'h0});
    rd_en[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 16'h0010;
    wdata[0] = 32'hCAFEF00D; wmask[0] = 4'hF;
    @(negedge clk);
    check("t5_wr_only", {60'd0, s_wr_en, s_rd_en, wr_ack[0], rd_valid[0]}, 64'b1010);
    @(posedge clk); #1 wr_en[0] = 1'b0;
    @(negedge clk);
    check("t5_rd_next", 64'(s_rd_en), 64'd1);
    wait_done(0, 1'b0, c);
    rd_en[0] = 1'b0;

    // 6: reset while an m1 read is in flight, valid arrives during/after reset
    mem_off = 1'b1;
    rd_en[1] = 1'b1; addr[1] = 16'h0020;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (s_rd_en) break;
    end
    check("t6_fwd", 64'(s_rd_en), 64'd1);
    @(posedge clk); #1;
    check("t6_inflight", 64'(dut.in_flight), 64'd1);
    rst_n = 1'b0; rd_en[1] = 1'b0; inj = 1'b1;
    #1 check("t6_rst_clr", 64'(dut.in_flight), 64'd0);
    @(negedge clk);
    check("t6_no_valid_rst", {62'd0, rd_valid[0], rd_valid[1]}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_late_ignored", {62'd0, rd_valid[0], rd_valid[1]}, 64'd0);
    check("t6_s_idle", 64'(idle_vec()), 64'(IDLE));
    check("t6_owner", 64'(dut.owner), 64'd0);
    @(posedge clk); #1 inj = 1'b0; mem_off = 1'b0;

    repeat (2) @(posedge clk);
    check("sb_drain", 64'(q0.size() + q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
